// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, constants and helpers for the load/store memory stage.
// Holds the RISC-V funct3 encodings, the stage state enum and address helpers.
package lsu_pkg;

  localparam int MEM_AW_DEFAULT = 30;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  // Loads have no encoding at 111; stores only exist at 000..011.
  function automatic logic isIllegalF3(input logic isStore, input logic [2:0] f3);
    return isStore ? f3[2] : (f3 == 3'b111);
  endfunction

  // Access size is funct3[1:0]: 0=byte, 1=half, 2=word, 3=double.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      2'b01:   return lo[0];
      2'b10:   return |lo[1:0];
      2'b11:   return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Round the low address bits down to the natural boundary of the access.
  function automatic logic [2:0] alignLo(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      2'b01:   return {lo[2:1], 1'b0};
      2'b10:   return {lo[2], 2'b00};
      2'b11:   return 3'b000;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane steering between a 64-bit register value and the
// 32-bit memory port. Produces store strobes/replicated write data and the
// extracted, sign- or zero-extended load value.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addrLo_i,
  input  logic        beat1_i,
  input  logic [63:0] wdata_i,
  input  logic [31:0] rdata0_i,
  input  logic [31:0] rdata1_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [63:0] ldata_o
);

  logic [31:0] lane;

  // Store side: replicate narrow data across all lanes, strobe only the target bytes.
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'h0;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << addrLo_i;
      end
      2'b01: begin
        wdata_o = {2{wdata_i[15:0]}};
        wstrb_o = 4'b0011 << addrLo_i;
      end
      2'b10: begin
        wdata_o = wdata_i[31:0];
        wstrb_o = 4'b1111;
      end
      default: begin
        wdata_o = beat1_i ? wdata_i[63:32] : wdata_i[31:0];
        wstrb_o = 4'b1111;
      end
    endcase
  end

  // Load side: shift the addressed bytes down to lane 0, then extend to 64 bits.
  always_comb begin
    lane    = rdata0_i >> {addrLo_i, 3'b000};
    ldata_o = 64'h0;
    case (funct3_i)
      LB:      ldata_o = {{56{lane[7]}}, lane[7:0]};
      LH:      ldata_o = {{48{lane[15]}}, lane[15:0]};
      LW:      ldata_o = {{32{lane[31]}}, lane};
      LD:      ldata_o = {rdata1_i, rdata0_i};
      LBU:     ldata_o = {56'h0, lane[7:0]};
      LHU:     ldata_o = {48'h0, lane[15:0]};
      LWU:     ldata_o = {32'h0, lane};
      default: ldata_o = 64'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage of the RV64 pipeline. Accepts one load or
// store from execute, runs one or two 32-bit beats on the word memory port
// (doublewords split into two beats) and returns load data or a fault.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses fault
// without touching memory; when undefined, they are rounded down to natural
// alignment and performed.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_fault,
  output logic              resp_wb_en,
  output logic [4:0]        resp_rd,
  output logic [63:0]       resp_data
);

  lsu_state_e  state_q;
  logic        isStore_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [4:0]  rd_q;
  logic        fault_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        reqFault;
  logic [2:0]  effLo;
  logic        inBeat;
  logic [MEM_AW-1:0] beatAddr;
  logic [3:0]  laneStrb;
  logic [31:0] laneWdata;
  logic [63:0] laneLoad;

`ifdef LSU_MISALIGN_TRAP_EN
  assign reqFault = isIllegalF3(req_is_store, req_funct3) |
                    isMisaligned(req_funct3[1:0], req_addr[2:0]);
  assign effLo    = addr_q[2:0];
`else
  assign reqFault = isIllegalF3(req_is_store, req_funct3);
  assign effLo    = alignLo(funct3_q[1:0], addr_q[2:0]);
`endif

  // The raw address is kept so a fault can report it; the beat address is
  // derived from the aligned low bits, stepping to the next word for beat 1.
  assign inBeat   = (state_q == BEAT0) || (state_q == BEAT1);
  assign beatAddr = {addr_q[MEM_AW+1:3], effLo[2]} + MEM_AW'(state_q == BEAT1);

  lsu_lane_align u_lane (
    .funct3_i (funct3_q),
    .addrLo_i (effLo[1:0]),
    .beat1_i  (state_q == BEAT1),
    .wdata_i  (wdata_q),
    .rdata0_i (rdata0_q),
    .rdata1_i (rdata1_q),
    .wstrb_o  (laneStrb),
    .wdata_o  (laneWdata),
    .ldata_o  (laneLoad)
  );

  // Sequencer: capture the request, walk the memory beats, hold the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      isStore_q <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= 64'h0;
      wdata_q   <= 64'h0;
      rd_q      <= 5'd0;
      fault_q   <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            isStore_q <= req_is_store;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rd_q      <= req_rd;
            fault_q   <= reqFault;
            state_q   <= reqFault ? RESP : BEAT0;
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            rdata0_q <= mem_rdata;
            state_q  <= (funct3_q[1:0] == 2'b11) ? BEAT1 : RESP;
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            rdata1_q <= mem_rdata;
            state_q  <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode from registered state; everything is zero outside its phase.
  always_comb begin
    req_ready  = (state_q == IDLE) && !reset;
    mem_valid  = inBeat;
    mem_we     = inBeat && isStore_q;
    mem_addr   = inBeat ? beatAddr : '0;
    mem_wstrb  = (inBeat && isStore_q) ? laneStrb : 4'b0000;
    mem_wdata  = (inBeat && isStore_q) ? laneWdata : 32'h0;
    resp_valid = (state_q == RESP);
    resp_fault = resp_valid && fault_q;
    resp_wb_en = resp_valid && !fault_q && !isStore_q && (rd_q != 5'd0);
    resp_rd    = resp_valid ? rd_q : 5'd0;
    resp_data  = 64'h0;
    if (resp_valid) begin
      if (fault_q)         resp_data = addr_q;
      else if (!isStore_q) resp_data = laneLoad;
    end
  end

endmodule
